// File: rtl/march_sequencer.sv
// PMBIST march sequencer: fetches march elements from an async ROM, walks memory, issues R/W ops and compares reads.
// Optional PMBIST_FAIL_CAPTURE_EN adds first-failure address/bit-mask capture ports.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module march_sequencer #(
  parameter int AW = 4,
  parameter int DW = `DATA_WIDTH,
  parameter int IW = 3
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  output logic [IW-1:0] instr_addr_out,
  input  logic [11:0]   instr_in,
  input  logic [DW-1:0] pattern_in,
  output logic [AW-1:0] mem_addr_out,
  output logic [DW-1:0] mem_wdata_out,
  output logic          mem_we_out,
  output logic          mem_re_out,
  input  logic [DW-1:0] mem_rdata_in,
  output logic          busy_out,
  output logic          done_out,
`ifdef PMBIST_FAIL_CAPTURE_EN
  output logic [AW-1:0] fail_addr_out,
  output logic [DW-1:0] fail_data_out,
`endif
  output logic          fail_out
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  state_t        state_q;
  logic [11:0]   ir_q;
  logic [1:0]    k_q;
  logic [AW-1:0] addr_q;
  logic          we_q, re_q;
  logic [DW-1:0] wdata_q, exp_q;
  logic          cmp_vld_q, fail_q;
  logic [IW-1:0] iaddr_q;
`ifdef PMBIST_FAIL_CAPTURE_EN
  logic [AW-1:0] cmp_addr_q, cap_addr_q;
  logic [DW-1:0] cap_data_q;
`endif

  logic [1:0]    k_d;
  logic [AW-1:0] addr_d;
  logic [1:0]    op_d;
  logic          last_op_d, elem_end_d, miscmp_d;

  always_comb begin
    last_op_d  = (k_q == ir_q[9:8]);
    k_d        = last_op_d ? 2'd0 : k_q + 2'd1;
    addr_d     = addr_q;
    if (last_op_d)
      addr_d = ir_q[10] ? addr_q - AW'(1) : addr_q + AW'(1);
    op_d       = ir_q[{k_d, 1'b0} +: 2];
    elem_end_d = last_op_d && (addr_q == (ir_q[10] ? {AW{1'b0}} : {AW{1'b1}}));
    // The read issued last cycle returns its data now; compare against the registered expectation.
    miscmp_d   = cmp_vld_q && (mem_rdata_in != exp_q);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      k_q       <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      wdata_q   <= '0;
      exp_q     <= '0;
      cmp_vld_q <= 1'b0;
      fail_q    <= 1'b0;
      iaddr_q   <= '0;
`ifdef PMBIST_FAIL_CAPTURE_EN
      cmp_addr_q <= '0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
`endif
    end else begin
      cmp_vld_q <= re_q;
      exp_q     <= wdata_q;
      if (miscmp_d)
        fail_q <= 1'b1;
`ifdef PMBIST_FAIL_CAPTURE_EN
      cmp_addr_q <= addr_q;
      if (miscmp_d && !fail_q) begin
        cap_addr_q <= cmp_addr_q;
        cap_data_q <= mem_rdata_in ^ exp_q;
      end
`endif
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            state_q <= S_FETCH;
            fail_q  <= 1'b0;
            iaddr_q <= '0;
`ifdef PMBIST_FAIL_CAPTURE_EN
            cap_addr_q <= '0;
            cap_data_q <= '0;
`endif
          end
        end
        S_FETCH: begin
          ir_q    <= instr_in;
          k_q     <= 2'd0;
          addr_q  <= instr_in[10] ? {AW{1'b1}} : {AW{1'b0}};
          we_q    <= instr_in[1];
          re_q    <= ~instr_in[1];
          wdata_q <= pattern_in ^ {DW{instr_in[0]}};
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (elem_end_d) begin
            we_q <= 1'b0;
            re_q <= 1'b0;
            // Program ends on the last flag or at the top ROM slot; the ROM address never wraps.
            if (ir_q[11] || (iaddr_q == {IW{1'b1}})) begin
              state_q <= S_DONE;
            end else begin
              iaddr_q <= iaddr_q + IW'(1);
              state_q <= S_FETCH;
            end
          end else begin
            k_q     <= k_d;
            addr_q  <= addr_d;
            we_q    <= op_d[1];
            re_q    <= ~op_d[1];
            wdata_q <= pattern_in ^ {DW{op_d[0]}};
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_addr_out = iaddr_q;
  assign mem_addr_out   = addr_q;
  assign mem_wdata_out  = wdata_q;
  assign mem_we_out     = we_q;
  assign mem_re_out     = re_q;
  assign busy_out       = (state_q != S_IDLE);
  assign done_out       = (state_q == S_DONE);
  assign fail_out       = fail_q | miscmp_d;
`ifdef PMBIST_FAIL_CAPTURE_EN
  assign fail_addr_out  = cap_addr_q;
  assign fail_data_out  = cap_data_q;
`endif

endmodule

// File: tb/tb_march_sequencer.sv
// Directed bench for march_sequencer (AW=4, DW=8, IW=3) with a 1-cycle-latency memory model and stuck-at fault injection.
module tb_march_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] iaddr;
  logic [11:0] instr;
  logic [7:0] pattern = 8'h00;
  logic [3:0] maddr;
  logic [7:0] wdata;
  logic       mem_we, mem_re;
  logic [7:0] rdata = 8'h00;
  logic       busy, done, fail;
`ifdef PMBIST_FAIL_CAPTURE_EN
  logic [3:0] fail_addr;
  logic [7:0] fail_data;
`endif

  logic [11:0] rom [8];
  logic [7:0]  mem [16];
  int          stuck_addr = -1;
  logic [7:0]  stuck_mask = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  logic       tr_we [200];
  logic       tr_re [200];
  logic       tr_busy [200];
  logic       tr_fail [200];
  logic [3:0] tr_addr [200];
  logic [7:0] tr_wd [200];
  logic [2:0] tr_ia [200];

  always #5 clk = ~clk;

  assign instr = rom[iaddr];

  always @(posedge clk) begin
    if (mem_we) mem[maddr] <= wdata;
    if (mem_re) rdata <= mem[maddr] | ((int'(maddr) == stuck_addr) ? stuck_mask : 8'h00);
  end

  march_sequencer #(.AW(4), .DW(8), .IW(3)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .instr_addr_out(iaddr), .instr_in(instr), .pattern_in(pattern),
    .mem_addr_out(maddr), .mem_wdata_out(wdata), .mem_we_out(mem_we), .mem_re_out(mem_re),
    .mem_rdata_in(rdata), .busy_out(busy), .done_out(done),
`ifdef PMBIST_FAIL_CAPTURE_EN
    .fail_addr_out(fail_addr), .fail_data_out(fail_data),
`endif
    .fail_out(fail)
  );

  // Pulse start, then record one sample per cycle (cycle 1 = FETCH) until done_out or the budget runs out.
  task automatic run_prog(input int max_cyc, output int dcyc);
    dcyc = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= max_cyc && c < 200; c++) begin
      @(negedge clk);
      tr_we[c] = mem_we; tr_re[c] = mem_re; tr_busy[c] = busy; tr_fail[c] = fail;
      tr_addr[c] = maddr; tr_wd[c] = wdata; tr_ia[c] = iaddr;
      if (done) begin dcyc = c; break; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, fail, mem_we, mem_re} !== 5'b0 || iaddr !== 3'd0 || maddr !== 4'd0 || wdata !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%b done=%b fail=%b we=%b re=%b ia=%0d addr=%0d wd=%h, all required 0",
               busy, done, fail, mem_we, mem_re, iaddr, maddr, wdata);
    end
`ifdef PMBIST_FAIL_CAPTURE_EN
    n_cmp++;
    if (fail_addr !== 4'd0 || fail_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_capture: addr=%0d data=%h, required 0/00", fail_addr, fail_data);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single_write;
    int dc;
    rom[0] = 12'h802; pattern = 8'h3C;
    run_prog(40, dc);
    n_cmp++;
    if (dc !== 18) begin n_bad++; $display("FAIL s1_done_cycle: got %0d, required 18", dc); end
    n_cmp++;
    if (tr_busy[1] !== 1'b1 || tr_we[1] !== 1'b0 || tr_re[1] !== 1'b0) begin
      n_bad++; $display("FAIL s1_fetch: busy=%b we=%b re=%b, required 1/0/0", tr_busy[1], tr_we[1], tr_re[1]);
    end
    for (int c = 2; c <= 17; c++) begin
      n_cmp++;
      if (tr_we[c] !== 1'b1 || tr_re[c] !== 1'b0 || tr_addr[c] !== 4'(c - 2) || tr_wd[c] !== 8'h3C) begin
        n_bad++; $display("FAIL s1_write c%0d: we=%b re=%b addr=%0d wd=%h, required 1/0/%0d/3c",
                          c, tr_we[c], tr_re[c], tr_addr[c], tr_wd[c], c - 2);
      end
    end
    n_cmp++;
    if (tr_fail[18] !== 1'b0 || tr_busy[18] !== 1'b1) begin
      n_bad++; $display("FAIL s1_done_state: fail=%b busy=%b, required 0/1", tr_fail[18], tr_busy[18]);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL s1_back_idle: busy=%b done=%b, required 0/0", busy, done);
    end
  endtask

  task automatic test_write_read(input bit faulty);
    int dc;
    rom[0] = 12'h002; rom[1] = 12'hC00; pattern = 8'h5A;
    stuck_addr = faulty ? 5 : -1; stuck_mask = 8'h04;
    run_prog(60, dc);
    n_cmp++;
    if (dc !== 35) begin n_bad++; $display("FAIL wr_done_cycle: got %0d, required 35", dc); end
    n_cmp++;
    if (tr_we[18] !== 1'b0 || tr_re[18] !== 1'b0 || tr_ia[18] !== 3'd1) begin
      n_bad++; $display("FAIL wr_fetch2: we=%b re=%b ia=%0d, required 0/0/1", tr_we[18], tr_re[18], tr_ia[18]);
    end
    for (int c = 19; c <= 34; c++) begin
      n_cmp++;
      if (tr_re[c] !== 1'b1 || tr_we[c] !== 1'b0 || tr_addr[c] !== 4'(15 - (c - 19))) begin
        n_bad++; $display("FAIL wr_read c%0d: re=%b we=%b addr=%0d, required 1/0/%0d",
                          c, tr_re[c], tr_we[c], tr_addr[c], 15 - (c - 19));
      end
    end
    if (!faulty) begin
      n_cmp++;
      if (tr_fail[35] !== 1'b0) begin n_bad++; $display("FAIL s2_fail: got %b, required 0", tr_fail[35]); end
    end else begin
      n_cmp++;
      if (tr_fail[29] !== 1'b0 || tr_fail[30] !== 1'b1 || tr_fail[35] !== 1'b1) begin
        n_bad++; $display("FAIL s3_fail_timing: c29=%b c30=%b c35=%b, required 0/1/1",
                          tr_fail[29], tr_fail[30], tr_fail[35]);
      end
      @(negedge clk); @(negedge clk);
`ifdef PMBIST_FAIL_CAPTURE_EN
      n_cmp++;
      if (fail_addr !== 4'd5 || fail_data !== 8'h04) begin
        n_bad++; $display("FAIL s3_capture: addr=%0d data=%h, required 5/04", fail_addr, fail_data);
      end
`endif
      n_cmp++;
      if (fail !== 1'b1) begin n_bad++; $display("FAIL s3_sticky: got %b, required 1", fail); end
    end
    stuck_addr = -1;
  endtask

  task automatic test_polarity;
    int dc;
    rom[0] = 12'h803; pattern = 8'hA5;
    run_prog(40, dc);
    n_cmp++;
    if (dc !== 18 || tr_fail[1] !== 1'b0) begin
      n_bad++; $display("FAIL s4_done_clear: done_c=%0d fail_c1=%b, required 18/0", dc, tr_fail[1]);
    end
    for (int c = 2; c <= 17; c++) begin
      n_cmp++;
      if (tr_we[c] !== 1'b1 || tr_wd[c] !== 8'h5A) begin
        n_bad++; $display("FAIL s4_wdata c%0d: we=%b wd=%h, required 1/5a", c, tr_we[c], tr_wd[c]);
      end
    end
  endtask

  task automatic test_multi_op;
    int dc;
    rom[0] = 12'h90E; pattern = 8'hA5;
    run_prog(60, dc);
    n_cmp++;
    if (dc !== 34) begin n_bad++; $display("FAIL mop_done_cycle: got %0d, required 34", dc); end
    for (int c = 2; c <= 33; c++) begin
      n_cmp++;
      if (tr_we[c] !== 1'b1 || tr_addr[c] !== 4'((c - 2) / 2) || tr_wd[c] !== (((c - 2) % 2) ? 8'h5A : 8'hA5)) begin
        n_bad++; $display("FAIL mop_op c%0d: we=%b addr=%0d wd=%h, required 1/%0d/%h", c, tr_we[c], tr_addr[c],
                          tr_wd[c], (c - 2) / 2, ((c - 2) % 2) ? 8'h5A : 8'hA5);
      end
    end
  endtask

  task automatic test_start_ignored_and_reset;
    int dc;
    rom[0] = 12'h802; pattern = 8'h3C;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 5) begin
        n_cmp++;
        if (mem_we !== 1'b1 || maddr !== 4'd3) begin
          n_bad++; $display("FAIL s5_start_ignored: we=%b addr=%0d, required 1/3", mem_we, maddr);
        end
      end
      if (c >= 9) begin
        n_cmp++;
        if (busy !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 || done !== 1'b0) begin
          n_bad++; $display("FAIL s5_after_reset c%0d: busy=%b we=%b re=%b done=%b, required 0", c, busy, mem_we, mem_re, done);
        end
      end
      if (c == 3) start = 1'b1;
      if (c == 4) start = 1'b0;
      if (c == 8) rst = 1'b1;
      if (c == 9) rst = 1'b0;
    end
    run_prog(40, dc);
    n_cmp++;
    if (dc !== 18 || tr_addr[17] !== 4'd15) begin
      n_bad++; $display("FAIL s5_rerun: done_c=%0d last_addr=%0d, required 18/15", dc, tr_addr[17]);
    end
  endtask

  task automatic test_full_rom;
    int dc;
    for (int i = 0; i < 8; i++) rom[i] = 12'h002;
    pattern = 8'h0F;
    run_prog(190, dc);
    n_cmp++;
    if (dc !== 137) begin n_bad++; $display("FAIL s6_done_cycle: got %0d, required 137", dc); end
    for (int e = 0; e < 8; e++) begin
      n_cmp++;
      if (tr_ia[1 + 17 * e] !== 3'(e) || tr_we[1 + 17 * e] !== 1'b0 || tr_ia[17 + 17 * e] !== 3'(e)) begin
        n_bad++; $display("FAIL s6_slot%0d: ia_fetch=%0d we=%b ia_end=%0d, required %0d/0/%0d",
                          e, tr_ia[1 + 17 * e], tr_we[1 + 17 * e], tr_ia[17 + 17 * e], e, e);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
        n_bad++; $display("FAIL s6_single_done +%0d: done=%b busy=%b we=%b, required 0", c, done, busy, mem_we);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 12'h000;
    test_reset;
    test_single_write;
    test_write_read(1'b0);
    test_write_read(1'b1);
    test_polarity;
    test_multi_op;
    test_start_ignored_and_reset;
    test_full_rom;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
